imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance edge to rsp_valid assertion (legal 1..4).
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of storage depth in 16-bit words.
REQ-003 SHALL have port clk input 1: single clock, all state updates on rising edge.
REQ-004 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid input 1: fetch presents a read request.
REQ-006 SHALL have port req_addr input 16: byte address of instruction (halfword aligned).
REQ-007 SHALL have port req_ready output 1: block can accept a request this cycle.
REQ-008 SHALL have port rsp_valid output 1: rsp_data/rsp_err are valid.
REQ-009 SHALL have port rsp_data output 16: instruction word read.
REQ-010 SHALL have port rsp_err output 1: misaligned-request flag.
REQ-011 SHALL have port rsp_ready input 1: fetch consumes the response.
REQ-012 SHALL have port ld_en input 1: preload write strobe.
REQ-013 SHALL have port ld_addr input 16: preload byte address.
REQ-014 SHALL have port ld_data input 16: preload word.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE with rst low.
REQ-016 SHALL accept a request on an edge where req_valid && req_ready, latching word index req_addr[DEPTH_LOG2:1]; upper bits ignored (address wraps).
REQ-017 SHALL on acceptance go to RESP if LATENCY=1, else to WAIT with a 2-bit down-counter loaded with LATENCY-2.
REQ-018 SHALL in WAIT decrement the counter each edge and go to RESP on the edge where the counter is 0.
REQ-019 SHALL capture rsp_data from storage on the edge entering RESP, so rsp_valid rises exactly LATENCY edges after acceptance.
REQ-020 SHALL hold rsp_valid, rsp_data, rsp_err stable in RESP until an edge with rsp_ready=1, then return to IDLE and drop rsp_valid.
REQ-021 SHALL accept no new request in WAIT or RESP; earliest next acceptance is the edge after the response handshake edge.
REQ-022 SHALL write ld_data to word ld_addr[DEPTH_LOG2:1] on every edge with ld_en=1, in any state.
REQ-023 SHALL give read-before-write on collision: a load to the word captured on the same edge returns old data; loads on earlier edges are visible.
REQ-024 SHALL ignore req_valid while rst is high and leave pending state unaffected by req_valid outside IDLE.

Reset
REQ-025 SHALL on rst assertion immediately force state IDLE, counter 0, rsp_valid 0, rsp_data 16'h0000, rsp_err 0, req_ready 0.
REQ-026 SHALL abandon any in-flight request on reset mid-operation; no response is ever issued for it.
REQ-027 SHALL leave storage contents unchanged by reset.
REQ-028 SHALL assert req_ready in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with IMEM_RESP_ERR_EN defined, set rsp_err = latched req_addr[0] and return rsp_data 16'h0000 for misaligned requests, latency unchanged.
REQ-030 SHALL, without IMEM_RESP_ERR_EN, tie rsp_err to 0 and ignore req_addr[0] (read the aligned word).

Verification
REQ-031 SHALL cover: LATENCY=2, preload word 0x0002=16'hA5C3, request addr 16'h0002 at edge N -> rsp_valid at edge N+2, rsp_data 16'hA5C3, req_ready 0 during N+1..handshake.
REQ-032 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data 16'hA5C3 stable all 5 cycles, req_valid ignored; rsp_ready=1 -> IDLE, req_ready 1 next cycle.
REQ-033 SHALL cover: LATENCY=1 and LATENCY=4, request addr 16'h0010 -> rsp_valid exactly 1 and 4 edges after acceptance.
REQ-034 SHALL cover: rst pulsed in WAIT -> rsp_valid 0, rsp_data 16'h0000 immediately, no response after release, preloaded data intact on re-read.
REQ-035 SHALL cover: ld_en to word 0x0004 with 16'h1234 on capture edge of request 16'h0004 holding 16'hFFFF -> rsp_data 16'hFFFF; re-request -> 16'h1234.
REQ-036 SHALL cover: addr 16'h0003 -> with IMEM_RESP_ERR_EN rsp_err 1 and rsp_data 16'h0000; without it rsp_err 0 and word at 0x0002 returned.

Source files
------------

// File: rtl/imem_resp.sv
// rtl/imem_resp.sv - instruction memory with fixed-latency request/response handshake
//
// Purpose: word-addressed 16-bit instruction store. A fetch request is accepted
// in IDLE, the response appears LATENCY edges later (counted at the sampling
// edge) and is held until the fetch side takes it with rsp_ready.
// Optional feature macro: IMEM_RESP_ERR_EN (flag misaligned requests via rsp_err).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_addr       fetch request (byte address), req_ready accept
//   rsp_valid/rsp_data/rsp_err response, consumed with rsp_ready
//   ld_en/ld_addr/ld_data    preload write port, active in every state

module imem_resp #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [15:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    input  logic        rsp_ready,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter preload for the WAIT phase; unused when LATENCY is 1.
    localparam logic [1:0] LAT_M2 = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    logic [15:0]           mem_q [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  odd_q, odd_d;
    logic                  valid_q, valid_d;
    logic [15:0]           data_q, data_d;
    logic                  err_q, err_d;

    logic                  capture;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_odd;
    logic                  cap_err;

    assign req_idx = req_addr[DEPTH_LOG2:1];

    // With LATENCY=1 the capture happens on the acceptance edge itself, so
    // the read must use the live request address rather than the latch.
    assign rd_idx = (state_q == S_IDLE) ? req_idx : idx_q;
    assign rd_odd = (state_q == S_IDLE) ? req_addr[0] : odd_q;

`ifdef IMEM_RESP_ERR_EN
    assign cap_err = rd_odd;
`else
    assign cap_err = 1'b0;
    logic unused_odd;
    assign unused_odd = rd_odd;
`endif

    logic unused_addr;
    assign unused_addr = ^{req_addr[15:DEPTH_LOG2+1], ld_addr[15:DEPTH_LOG2+1], ld_addr[0]};

    // Storage is deliberately outside the reset domain. The non-blocking
    // write gives read-before-write against a capture on the same edge.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr[DEPTH_LOG2:1]] <= ld_data;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        odd_d   = odd_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    idx_d = req_idx;
                    odd_d = req_addr[0];
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        capture = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M2;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 2'd0) begin
                    state_d = S_RESP;
                    capture = 1'b1;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (capture) begin
            valid_d = 1'b1;
            err_d   = cap_err;
            data_d  = cap_err ? 16'h0000 : mem_q[rd_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= '0;
            odd_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            odd_q   <= odd_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_resp.sv
// tb/tb_imem_resp.sv - self-checking bench for imem_resp at LATENCY 1, 2 and 4

module tb_imem_resp;

`ifdef IMEM_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [15:0] req_addr;
    logic        rsp_ready;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    logic [2:0]  rr, rv, re;
    logic [15:0] rd [3];

    int lat [3] = '{1, 2, 4};

    int vectors = 0;
    int errs    = 0;

    logic [15:0] mem_m [256];

    always #5 clk = ~clk;

    imem_resp #(.LATENCY(1), .DEPTH_LOG2(8)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rr[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]), .rsp_err(re[0]),
        .rsp_ready(rsp_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    imem_resp #(.LATENCY(2), .DEPTH_LOG2(8)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rr[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]), .rsp_err(re[1]),
        .rsp_ready(rsp_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    imem_resp #(.LATENCY(4), .DEPTH_LOG2(8)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rr[2]), .rsp_valid(rv[2]), .rsp_data(rd[2]), .rsp_err(re[2]),
        .rsp_ready(rsp_ready), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

    task automatic chk(input string tag, input int inst, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s lat=%0d observed=%h expected=%h", tag, lat[inst], obs, exp);
        end
    endtask

    // Reference value of a read: misaligned reads are zero when flagged,
    // otherwise the halfword address simply drops bit 0 and wraps at 256 words.
    function automatic logic [15:0] ref_data(input logic [15:0] a);
        return (ERR_EN && a[0]) ? 16'h0000 : mem_m[a[8:1]];
    endfunction

    // One request/response exchange, entered and left at a negedge with all
    // instances idle. ld_k >= 0 plants a load on edge ld_k after acceptance
    // (0 = acceptance edge); ld_k == -1 sprinkles random loads; -2 no loads.
    task automatic txn(input logic [15:0] addr, input int ld_k,
                       input logic [15:0] la, input logic [15:0] lv);
        logic [15:0] exp_d [3];
        logic        exp_e [3];
        for (int i = 0; i < 3; i++) chk("ready_idle", i, 16'(rr[i]), 16'h1);
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b0;
        ld_en     = (ld_k == 0);
        ld_addr   = la;
        ld_data   = lv;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk);
            // Instance with latency L samples storage on edge L-1 after acceptance.
            for (int i = 0; i < 3; i++) begin
                if (lat[i] - 1 == e) begin
                    exp_d[i] = ref_data(addr);
                    exp_e[i] = ERR_EN && addr[0];
                end
            end
            if (ld_en) mem_m[ld_addr[8:1]] = ld_data;
            @(negedge clk);
            // The next edge is edge e+1 after acceptance: valid must be seen there iff e+1 >= L.
            for (int i = 0; i < 3; i++) begin
                chk("rsp_valid", i, 16'(rv[i]), 16'((e + 1) >= lat[i]));
                chk("ready_busy", i, 16'(rr[i]), 16'h0);
                if ((e + 1) >= lat[i]) begin
                    chk("rsp_data", i, rd[i], exp_d[i]);
                    chk("rsp_err", i, 16'(re[i]), 16'(exp_e[i]));
                end
            end
            // Requests while busy must be ignored.
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = 16'($urandom);
            if (ld_k >= 0) begin
                ld_en = (ld_k == e + 1);
            end else if (ld_k == -1) begin
                ld_en   = ($urandom_range(0, 3) == 0);
                ld_addr = 16'($urandom);
                ld_data = 16'($urandom);
            end else begin
                ld_en = 1'b0;
            end
        end
        req_valid = 1'b0;
        ld_en     = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("valid_after_hs", i, 16'(rv[i]), 16'h0);
            chk("ready_after_hs", i, 16'(rr[i]), 16'h1);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_valid"}, i, 16'(rv[i]), 16'h0);
            chk({tag, "_data"}, i, rd[i], 16'h0000);
            chk({tag, "_err"}, i, 16'(re[i]), 16'h0);
            chk({tag, "_ready"}, i, 16'(rr[i]), 16'h0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 16'h0000;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 16'h0000;
        ld_data   = 16'h0000;

        @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset");
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("ready_after_rst", i, 16'(rr[i]), 16'h1);

        // Preload every word; upper address bits are random to exercise wrap.
        for (int w = 0; w < 256; w++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = {7'($urandom), 8'(w), 1'($urandom)};
            ld_data = (w == 1) ? 16'hA5C3 : (w == 2) ? 16'hFFFF : 16'($urandom);
            @(posedge clk);
            mem_m[w] = ld_data;
        end
        @(negedge clk);
        ld_en = 1'b0;

        txn(16'h0002, -2, 16'h0, 16'h0);
        txn(16'h0010, -2, 16'h0, 16'h0);

        // Reset in the middle of a request: L2/L4 are in WAIT, L1 already in RESP.
        req_valid = 1'b1;
        req_addr  = 16'h0002;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) chk("ready_post_rst", i, 16'(rr[i]), 16'h1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk("no_rsp_after_rst", i, 16'(rv[i]), 16'h0);
        end
        txn(16'h0002, -2, 16'h0, 16'h0);

        // Load collides with the L2 capture edge (edge 1 after acceptance).
        txn(16'h0004, 1, 16'h0004, 16'h1234);
        txn(16'h0004, -2, 16'h0, 16'h0);
        txn(16'h0003, -2, 16'h0, 16'h0);

        for (int n = 0; n < 20; n++) begin
            txn(16'($urandom), -1, 16'h0, 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
